// File: rtl/jtag_host_pkg.sv
// Shared definitions for the JTAG virtual-DR host: sequencer states,
// TMS header pattern and default register lengths.
package jtag_host_pkg;

  localparam int DEF_IR_W     = 2;
  localparam int DEF_DR_W     = 8;
  localparam int INIT_TMS_LEN = 5;
  localparam int INIT_LEN     = INIT_TMS_LEN + 1;
  localparam int HDR_LEN      = 4;
  localparam int TAIL_LEN     = 2;

  // Read MSB first: 1,1,0,0 walks Select -> Select -> Capture -> Shift.
  localparam logic [3:0] HDR_TMS = 4'b1100;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_IR_HDR   = 3'd2,
    ST_IR_SHIFT = 3'd3,
    ST_DR_HDR   = 3'd4,
    ST_DR_SHIFT = 3'd5,
    ST_TAIL     = 3'd6
  } state_e;

  function automatic logic hdr_tms(input logic [1:0] idx);
    return HDR_TMS[2'd3 - idx];
  endfunction

endpackage

// File: rtl/jtag_shift_unit.sv
// TCK phase generator, per-segment bit counter, TDI serialiser and
// TDO deserialiser for the JTAG host.
module jtag_shift_unit
  import jtag_host_pkg::*;
#(
  parameter int IR_W  = DEF_IR_W,
  parameter int DR_W  = DEF_DR_W,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             i_active,
  input  logic             i_adv,
  input  logic             i_seg_last,
  input  logic             i_load,
  input  logic [IR_W-1:0]  i_ir,
  input  logic [DR_W-1:0]  i_dr,
  input  logic             i_next_shift,
  input  logic             i_cap,
  input  logic             i_tdo,
  output logic             o_tck,
  output logic             o_tdi,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_bit_cnt_nxt,
  output logic [DR_W-1:0]  o_cap_data
);

  localparam int TOT_W = IR_W + DR_W;

  logic             r_tck;
  logic             r_tdi;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TOT_W-1:0] r_tdi_sr;
  logic [DR_W-1:0]  r_tdo_sr;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_adv) begin
      if (i_seg_last) begin
        w_cnt_nxt = {CNT_W{1'b0}};
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // The IR bits sit below the DR bits so one LSB-first stream serves both scans.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_tck    <= 1'b0;
      r_tdi    <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_tdi_sr <= {TOT_W{1'b0}};
      r_tdo_sr <= {DR_W{1'b0}};
    end else begin
      if (i_active) begin
        r_tck <= ~r_tck;
      end else begin
        r_tck <= 1'b0;
      end
      r_cnt <= w_cnt_nxt;
      if (i_load) begin
        r_tdi_sr <= {i_dr, i_ir};
      end else if (i_adv && i_next_shift) begin
        r_tdi_sr <= {1'b0, r_tdi_sr[TOT_W-1:1]};
      end
      if (i_adv) begin
        r_tdi <= i_next_shift ? r_tdi_sr[0] : 1'b0;
      end
      if (i_cap) begin
        r_tdo_sr <= {i_tdo, r_tdo_sr[DR_W-1:1]};
      end
    end
  end

  assign o_tck         = r_tck;
  assign o_tdi         = r_tdi;
  assign o_bit_cnt     = r_cnt;
  assign o_bit_cnt_nxt = w_cnt_nxt;
  assign o_cap_data    = r_tdo_sr;

endmodule

// File: rtl/jtag_vdr_host.sv
// JTAG host that resets the TAP, then runs one IR scan followed by one DR
// scan per start request and returns the captured DR contents.
module jtag_vdr_host
  import jtag_host_pkg::*;
#(
  parameter int IR_W = DEF_IR_W,
  parameter int DR_W = DEF_DR_W
) (
  input  logic            clk,
  input  logic            aclr,
  input  logic            start,
  input  logic [IR_W-1:0] ir_val,
  input  logic [DR_W-1:0] dr_wr,
  output logic [DR_W-1:0] dr_rd,
  output logic            busy,
  output logic            done,
  output logic            jtag_tck,
  output logic            jtag_tms,
  output logic            jtag_tdi,
  input  logic            jtag_tdo
);

  localparam int CNT_W = $clog2(IR_W + DR_W + INIT_LEN + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_tms;
  logic             w_tms_nxt;
  logic             r_busy;
  logic             r_done;
  logic [DR_W-1:0]  r_dr_rd;
  logic             w_active;
  logic             w_accept;
  logic             w_adv;
  logic             w_last;
  logic             w_done_nxt;
  logic             w_next_shift;
  logic             w_cap;
  logic             w_tck;
  logic             w_tdi;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DR_W-1:0]  w_cap_data;

  // A bit advances on the edge that ends phase1, or on the accepting edge.
  assign w_active     = (r_state != ST_IDLE);
  assign w_accept     = (r_state == ST_IDLE) && start && !r_done;
  assign w_adv        = (w_active && w_tck) || w_accept;
  assign w_cap        = (r_state == ST_DR_SHIFT) && !w_tck;
  assign w_done_nxt   = w_adv && (r_state == ST_TAIL) && w_last;
  assign w_next_shift = (w_state_nxt == ST_IR_SHIFT) || (w_state_nxt == ST_DR_SHIFT);

  always_comb begin
    w_last = 1'b1;
    case (r_state)
      ST_INIT:     w_last = (w_cnt == CNT_W'(INIT_LEN - 1));
      ST_IR_HDR:   w_last = (w_cnt == CNT_W'(HDR_LEN - 1));
      ST_IR_SHIFT: w_last = (w_cnt == CNT_W'(IR_W - 1));
      ST_DR_HDR:   w_last = (w_cnt == CNT_W'(HDR_LEN - 1));
      ST_DR_SHIFT: w_last = (w_cnt == CNT_W'(DR_W - 1));
      ST_TAIL:     w_last = (w_cnt == CNT_W'(TAIL_LEN - 1));
      ST_IDLE:     w_last = 1'b1;
      default:     w_last = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_adv && w_last) begin
      case (r_state)
        ST_INIT:     w_state_nxt = ST_IDLE;
        ST_IDLE:     w_state_nxt = ST_IR_HDR;
        ST_IR_HDR:   w_state_nxt = ST_IR_SHIFT;
        ST_IR_SHIFT: w_state_nxt = ST_DR_HDR;
        ST_DR_HDR:   w_state_nxt = ST_DR_SHIFT;
        ST_DR_SHIFT: w_state_nxt = ST_TAIL;
        ST_TAIL:     w_state_nxt = ST_IDLE;
        default:     w_state_nxt = ST_INIT;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // TMS is decoded for the bit about to start, so it only moves when a bit begins.
  always_comb begin
    w_tms_nxt = 1'b0;
    case (w_state_nxt)
      ST_INIT:     w_tms_nxt = (w_cnt_nxt < CNT_W'(INIT_TMS_LEN));
      ST_IR_HDR:   w_tms_nxt = hdr_tms(w_cnt_nxt[1:0]);
      ST_IR_SHIFT: w_tms_nxt = (w_cnt_nxt == CNT_W'(IR_W - 1));
      ST_DR_HDR:   w_tms_nxt = hdr_tms(w_cnt_nxt[1:0]);
      ST_DR_SHIFT: w_tms_nxt = (w_cnt_nxt == CNT_W'(DR_W - 1));
      ST_TAIL:     w_tms_nxt = (w_cnt_nxt == {CNT_W{1'b0}});
      ST_IDLE:     w_tms_nxt = 1'b0;
      default:     w_tms_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_state <= ST_INIT;
      r_tms   <= 1'b1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_dr_rd <= {DR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_tms   <= w_tms_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
      if (w_done_nxt) begin
        r_dr_rd <= w_cap_data;
      end
    end
  end

  jtag_shift_unit #(
    .IR_W  (IR_W),
    .DR_W  (DR_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk           (clk),
    .aclr          (aclr),
    .i_active      (w_active),
    .i_adv         (w_adv),
    .i_seg_last    (w_last),
    .i_load        (w_accept),
    .i_ir          (ir_val),
    .i_dr          (dr_wr),
    .i_next_shift  (w_next_shift),
    .i_cap         (w_cap),
    .i_tdo         (jtag_tdo),
    .o_tck         (w_tck),
    .o_tdi         (w_tdi),
    .o_bit_cnt     (w_cnt),
    .o_bit_cnt_nxt (w_cnt_nxt),
    .o_cap_data    (w_cap_data)
  );

  assign dr_rd    = r_dr_rd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign jtag_tck = w_tck;
  assign jtag_tms = r_tms;
  assign jtag_tdi = w_tdi;

endmodule

// File: tb/tb_jtag_vdr_host.sv
// Bench for jtag_vdr_host: a behavioural 16-state TAP target (2-bit IR,
// write-only DR1, DR2 capturing 0xA5, bypass otherwise) plus randomized scans.
module tb_jtag_vdr_host;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDS, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIS, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_e;

  logic       clk = 1'b0;
  logic       aclr = 1'b1;
  logic       start = 1'b0;
  logic [1:0] ir_val = 2'd0;
  logic [7:0] dr_wr = 8'd0;
  logic [7:0] dr_rd;
  logic       busy, done, jtag_tck, jtag_tms, jtag_tdi;

  tap_e       t_st = T_TLR;
  logic [1:0] t_ir = 2'd3;
  logic [1:0] t_isr = 2'd0;
  logic [7:0] t_dsr = 8'd0;
  logic [7:0] t_dr1 = 8'd0;
  logic       t_tdo = 1'b0;
  int         tck_cnt = 0;
  logic       tms_q[$];

  int n_vec = 0;
  int n_err = 0;

  jtag_vdr_host dut (
    .clk      (clk),
    .aclr     (aclr),
    .start    (start),
    .ir_val   (ir_val),
    .dr_wr    (dr_wr),
    .dr_rd    (dr_rd),
    .busy     (busy),
    .done     (done),
    .jtag_tck (jtag_tck),
    .jtag_tms (jtag_tms),
    .jtag_tdi (jtag_tdi),
    .jtag_tdo (t_tdo)
  );

  always #5 clk = ~clk;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR  : T_RTI;
      T_RTI:   return m ? T_SDS  : T_RTI;
      T_SDS:   return m ? T_SIS  : T_CDR;
      T_CDR:   return m ? T_E1DR : T_SHDR;
      T_SHDR:  return m ? T_E1DR : T_SHDR;
      T_E1DR:  return m ? T_UDR  : T_PDR;
      T_PDR:   return m ? T_E2DR : T_PDR;
      T_E2DR:  return m ? T_UDR  : T_SHDR;
      T_UDR:   return m ? T_SDS  : T_RTI;
      T_SIS:   return m ? T_TLR  : T_CIR;
      T_CIR:   return m ? T_E1IR : T_SHIR;
      T_SHIR:  return m ? T_E1IR : T_SHIR;
      T_E1IR:  return m ? T_UIR  : T_PIR;
      T_PIR:   return m ? T_E2IR : T_PIR;
      T_E2IR:  return m ? T_UIR  : T_SHIR;
      default: return m ? T_SDS  : T_RTI;
    endcase
  endfunction

  // Target samples TMS/TDI on rising TCK
  always @(posedge jtag_tck) begin
    tck_cnt <= tck_cnt + 1;
    tms_q.push_back(jtag_tms);
    case (t_st)
      T_TLR:  t_ir <= 2'd3;
      T_CDR:  t_dsr <= (t_ir == 2'd2) ? 8'hA5 : 8'h00;
      T_SHDR: begin
        if (t_ir == 2'd1 || t_ir == 2'd2) t_dsr <= {jtag_tdi, t_dsr[7:1]};
        else t_dsr <= {7'd0, jtag_tdi};
      end
      T_UDR:  if (t_ir == 2'd1) t_dr1 <= t_dsr;
      T_CIR:  t_isr <= 2'b01;
      T_SHIR: t_isr <= {jtag_tdi, t_isr[1]};
      T_UIR:  t_ir <= t_isr;
      default: ;
    endcase
    t_st <= tap_next(t_st, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    t_tdo <= (t_st == T_SHDR) ? t_dsr[0] : ((t_st == T_SHIR) ? t_isr[0] : 1'b0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [1:0] ir, input logic [7:0] dr);
    if (ir == 2'd2) return 8'hA5;
    else if (ir == 2'd1) return 8'h00;
    else return {dr[6:0], 1'b0};
  endfunction

  function automatic int tms_pat(input int base);
    int pat = 0;
    for (int i = base; i < tms_q.size() && i < base + 16; i++) pat = (pat << 1) | int'(tms_q[i]);
    return pat;
  endfunction

  task automatic do_reset(input int hold);
    int base;
    int fall = -1;
    int n_done = 0;
    @(negedge clk);
    aclr = 1'b1;
    start = 1'b0;
    repeat (hold) @(negedge clk);
    check_eq("rst_tck", 32'(jtag_tck), 32'd0);
    check_eq("rst_tms", 32'(jtag_tms), 32'd1);
    check_eq("rst_tdi", 32'(jtag_tdi), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dr_rd", 32'(dr_rd), 32'd0);
    base = tms_q.size();
    aclr = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (done) n_done++;
      if (!busy && fall < 0) fall = e;
    end
    check_eq("init_busy_fall", 32'(fall), 32'd11);
    check_eq("init_tck_len", 32'(tms_q.size() - base), 32'd6);
    check_eq("init_tms_pat", 32'(tms_pat(base)), 32'h3E);
    check_eq("init_tap_rti", 32'(t_st), 32'(T_RTI));
    check_eq("init_no_done", 32'(n_done), 32'd0);
  endtask

  // dup_at/abort_at: edge offset from the accepting edge (0 = unused)
  task automatic do_txn(input logic [1:0] ir, input logic [7:0] dr,
                        input int dup_at, input int abort_at, input bit b2b);
    int done_at = -1, done_at2 = -1, n_done = 0, fall = -1, tcks = -1;
    int base = 0, t0, len;
    logic [7:0] rd = 8'd0;
    logic bsy = 1'b1, busy0 = 1'b0, busy41 = 1'b1, busy42 = 1'b0;
    len = b2b ? 110 : 60;
    @(negedge clk);
    check_eq("pre_busy", 32'(busy), 32'd0);
    ir_val = ir;
    dr_wr = dr;
    start = 1'b1;
    t0 = tck_cnt;
    for (int e = 0; e < len; e++) begin
      @(negedge clk);
      if (e == 0) busy0 = busy;
      if (e == 41) busy41 = busy;
      if (e == 42) busy42 = busy;
      if (!busy && fall < 0) fall = e;
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = e;
          rd = dr_rd;
          bsy = busy;
          tcks = tck_cnt - t0;
        end else if (done_at2 < 0) begin
          done_at2 = e;
        end
      end
      start = (e == dup_at - 1) || (b2b && (e == 40 || e == 41));
      aclr = (e == abort_at - 1);
      if (e == abort_at - 1) base = tms_q.size();
      if (b2b && (e == 40 || e == 41)) begin
        ir_val = ir;
        dr_wr = dr;
      end else begin
        ir_val = 2'($urandom_range(0, 3));
        dr_wr = 8'($urandom_range(0, 255));
      end
    end
    check_eq("accept_busy", 32'(busy0), 32'd1);
    if (abort_at > 0) begin
      check_eq("abort_no_done", 32'(n_done), 32'd0);
      check_eq("abort_busy_fall", 32'(fall), 32'(abort_at + 12));
      check_eq("abort_init_len", 32'(tms_q.size() - base), 32'd6);
      check_eq("abort_init_pat", 32'(tms_pat(base)), 32'h3E);
      check_eq("abort_tap_rti", 32'(t_st), 32'(T_RTI));
      check_eq("abort_dr_rd", 32'(dr_rd), 32'd0);
    end else begin
      check_eq("done_time", 32'(done_at), 32'd40);
      check_eq("done_count", 32'(n_done), b2b ? 32'd2 : 32'd1);
      check_eq("done_dr_rd", 32'(rd), 32'(exp_rd(ir, dr)));
      check_eq("done_busy", 32'(bsy), 32'd0);
      check_eq("tck_count", 32'(tcks), 32'd20);
      check_eq("tap_end_rti", 32'(t_st), 32'(T_RTI));
      check_eq("tap_ir", 32'(t_ir), 32'(ir));
      if (ir == 2'd1) check_eq("tap_dr1", 32'(t_dr1), 32'(dr));
      check_eq("hold_dr_rd", 32'(dr_rd), 32'(exp_rd(ir, dr)));
      check_eq("idle_pins", {29'd0, jtag_tck, jtag_tms, jtag_tdi}, 32'd0);
      if (b2b) begin
        check_eq("start_on_done_ignored", 32'(busy41), 32'd0);
        check_eq("start_after_done_taken", 32'(busy42), 32'd1);
        check_eq("second_done_time", 32'(done_at2), 32'd82);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset(3);
    do_txn(2'd1, 8'h3C, 0, 0, 1'b0);
    do_txn(2'd2, 8'h00, 0, 0, 1'b0);
    do_txn(2'd0, 8'h81, 0, 0, 1'b0);
    do_txn(2'd3, 8'h5A, 10, 0, 1'b0);
    do_txn(2'd2, 8'h11, 0, 0, 1'b1);
    do_txn(2'd2, 8'h77, 0, 15, 1'b0);
    do_txn(2'd0, 8'hC3, 0, 0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_txn(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 0, 0, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
